mono_video_colorizer: RTL

Parametrised colouriser for monochrome guest video. It maps an N-bit pixel intensity through a runtime-writable palette to RGB, delays sync and blank to stay aligned with the colour data, and applies palette and invert changes only at frame boundaries so a frame never tears. It sits between a guest video generator and the OSD/scandoubler video stage, and supersedes the fixed 1-bit, four-colour combinational mapping.

---
 rtl/mono_video_colorizer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mono_video_colorizer.sv
`default_nettype none
// ============================================================================
// Module      : mono_video_colorizer
// Description : Maps N-bit monochrome pixel intensity through a writable
//               palette to RGB, with frame-synchronous palette/invert select
//               and sync/blank delayed to match the colour pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mono_video_colorizer #(
   parameter  int IN_BITS  = 1,
   parameter  int OUT_BITS = 6,
   parameter  int PALETTES = 4,
   parameter  int PIPE     = 2,
   localparam int PS       = (PALETTES > 2) ? $clog2(PALETTES) : 1
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ce_pix,
   input  logic [IN_BITS-1:0]    pixel_in,
   input  logic                  hs_in,
   input  logic                  vs_in,
   input  logic                  blank_in,
   input  logic [PS-1:0]         pal_sel,
   input  logic                  invert,
   input  logic                  pal_wr,
   input  logic [PS-1:0]         pal_wr_idx,
   input  logic [3*OUT_BITS-1:0] pal_wr_data,
   output logic [OUT_BITS-1:0]   r_out,
   output logic [OUT_BITS-1:0]   g_out,
   output logic [OUT_BITS-1:0]   b_out,
   output logic                  hs_out,
   output logic                  vs_out,
   output logic                  blank_out
);

   localparam int c_CW = 3 * OUT_BITS;
   localparam int c_SW = c_CW + 3;

   logic [c_CW-1:0]    r_pal [PALETTES];
   logic [PS-1:0]      r_act_sel;
   logic               r_act_inv;
   logic               r_vs_prev;
   logic [IN_BITS-1:0] r_p;
   logic [c_CW-1:0]    r_c;
   logic               r_hs1;
   logic               r_vs1;
   logic               r_blank1;

   logic               w_wr_ok;
   logic               w_vs_rise;
   logic [PS-1:0]      w_rd_idx;
   logic [IN_BITS-1:0] w_p;
   logic [c_CW-1:0]    w_scaled;
   logic [c_SW-1:0]    w_stage;
   logic [c_SW-1:0]    w_out;

   // Defaults are given as 8-bit channels and truncated to the top OUT_BITS.
   function automatic logic [c_CW-1:0] pal_default(input int idx);
      logic [23:0] rgb8;
      case (idx)
         1:       rgb8 = 24'h33FF33;
         2:       rgb8 = 24'hFFCC00;
         3:       rgb8 = 24'h40FFA6;
         default: rgb8 = 24'hFFFFFF;
      endcase
      return {rgb8[23 -: OUT_BITS], rgb8[15 -: OUT_BITS], rgb8[7 -: OUT_BITS]};
   endfunction

   assign w_wr_ok   = int'(pal_wr_idx) < PALETTES;
   assign w_vs_rise = vs_in & ~r_vs_prev;
   assign w_rd_idx  = (int'(r_act_sel) < PALETTES) ? r_act_sel : '0;
   assign w_p       = r_act_inv ? ~pixel_in : pixel_in;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < PALETTES; i++) begin
            r_pal[i] <= pal_default(i);
         end
      end else if (pal_wr && w_wr_ok) begin
         r_pal[pal_wr_idx] <= pal_wr_data;
      end
   end

   // Stage 1 reads the palette before any same-cycle write lands.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_act_sel <= '0;
         r_act_inv <= 1'b0;
         r_vs_prev <= 1'b0;
         r_p       <= '0;
         r_c       <= '0;
         r_hs1     <= 1'b0;
         r_vs1     <= 1'b0;
         r_blank1  <= 1'b0;
      end else if (ce_pix) begin
         r_vs_prev <= vs_in;
         if (w_vs_rise) begin
            r_act_sel <= pal_sel;
            r_act_inv <= invert;
         end
         r_p      <= w_p;
         r_c      <= r_pal[w_rd_idx];
         r_hs1    <= hs_in;
         r_vs1    <= vs_in;
         r_blank1 <= blank_in;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic [OUT_BITS-1:0]         w_ch;
      logic [OUT_BITS+IN_BITS-1:0] w_prod;
      logic [OUT_BITS-1:0]         w_hi;
      logic [IN_BITS-1:0]          w_lo;
      logic                        w_unused_lo;

      assign w_ch          = r_c[ch*OUT_BITS +: OUT_BITS];
      assign w_prod        = {{IN_BITS{1'b0}}, w_ch} * {{OUT_BITS{1'b0}}, r_p};
      assign {w_hi, w_lo}  = w_prod;
      assign w_unused_lo   = ^w_lo;
      // Full intensity bypasses the product so it reaches the exact entry.
      assign w_scaled[ch*OUT_BITS +: OUT_BITS] =
         r_blank1      ? '0   :
         (&r_p)        ? w_ch :
         (r_p == '0)   ? '0   : w_hi;
   end

   assign w_stage = {w_scaled, r_hs1, r_vs1, r_blank1};

   if (PIPE > 1) begin : g_delay
      logic [c_SW-1:0] r_dly [PIPE-1];

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            for (int i = 0; i < PIPE - 1; i++) begin
               r_dly[i] <= '0;
            end
         end else if (ce_pix) begin
            r_dly[0] <= w_stage;
            for (int i = 1; i < PIPE - 1; i++) begin
               r_dly[i] <= r_dly[i-1];
            end
         end
      end

      assign w_out = r_dly[PIPE-2];
   end else begin : g_direct
      assign w_out = w_stage;
   end

   assign {r_out, g_out, b_out, hs_out, vs_out, blank_out} = w_out;

endmodule
`default_nettype wire
